// File: rtl/text_buffer_ctrl.sv
// Console text buffer: a 16x16 character RAM with a cursor that accepts a command byte stream.
// Handles printable characters, LF/CR/BS, form-feed clear and scroll-up. It also serves display reads.
module text_buffer_ctrl #(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter bit         SCROLL_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic [7:0] char_xy,
    output logic [7:0] char_code,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;

    state_t     state;
    logic [7:0] idx;
    logic [7:0] mem [256];

    logic       accept;
    logic       is_print;
    logic       do_advance;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] scroll_src;

    assign cmd_ready  = (state == IDLE);
    assign busy       = !cmd_ready;
    assign accept     = cmd_valid && cmd_ready;
    assign is_print   = (cmd_data >= 8'h20) && (cmd_data <= 8'h7E);
    assign do_advance = accept && ((is_print && cursor_x == 4'd15) || cmd_data == CODE_LF);
    // Only consumed while idx < 240, so the 8-bit sum never wraps.
    assign scroll_src = mem[idx + 8'd16];

    // Single write port, shared by character writes, backspace blanking, clear and scroll.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = BLANK_CHAR;
        unique case (state)
            IDLE: begin
                if (accept && is_print) begin
                    mem_we    = 1'b1;
                    mem_addr  = {cursor_y, cursor_x};
                    mem_wdata = cmd_data;
                end else if (accept && cmd_data == CODE_BS && cursor_x != 4'd0) begin
                    mem_we    = 1'b1;
                    mem_addr  = {cursor_y, cursor_x - 4'd1};
                    mem_wdata = BLANK_CHAR;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = idx;
                mem_wdata = BLANK_CHAR;
            end
            SCROLL: begin
                mem_we    = 1'b1;
                mem_addr  = idx;
                mem_wdata = (idx < 8'd240) ? scroll_src : BLANK_CHAR;
            end
            default: ;
        endcase
    end

    // NOTE: the RAM has no reset; the CLEAR pass that follows every reset initialises it.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    // Read-before-write: a same-cycle write to char_xy is seen on the following read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            char_code <= 8'h00;
        else
            char_code <= mem[char_xy];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            idx      <= 8'h00;
            cursor_x <= 4'd0;
            cursor_y <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            cursor_x <= (cursor_x == 4'd15) ? 4'd0 : cursor_x + 4'd1;
                        end else begin
                            unique case (cmd_data)
                                CODE_LF, CODE_CR: cursor_x <= 4'd0;
                                CODE_BS: if (cursor_x != 4'd0) cursor_x <= cursor_x - 4'd1;
                                CODE_FF: begin
                                    state    <= CLEAR;
                                    idx      <= 8'h00;
                                    cursor_x <= 4'd0;
                                    cursor_y <= 4'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    if (do_advance) begin
                        if (cursor_y != 4'd15) begin
                            cursor_y <= cursor_y + 4'd1;
                        end else if (SCROLL_EN) begin
                            state <= SCROLL;
                            idx   <= 8'h00;
                        end else begin
                            cursor_y <= 4'd0;
                        end
                    end
                end
                CLEAR, SCROLL: begin
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF)
                        state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
